pipe_adder: RTL and testbench
=============================

PIPE_ADDER -- requirements
Module: pipe_adder

Interface
REQ-001 SHALL provide parameter WIDTH, default 16, operand and sum width in bits.
REQ-002 SHALL provide parameter STAGES, default 4, pipeline depth; legal only when WIDTH % STAGES == 0 and STAGES >= 1.
REQ-003 SHALL provide port clk  input  1  single clock; all state updates on its rising edge.
REQ-004 SHALL provide port reset  input  1  asynchronous, active-high reset.
REQ-005 SHALL provide port A  input  WIDTH  operand A.
REQ-006 SHALL provide port B  input  WIDTH  operand B.
REQ-007 SHALL provide port Cin  input  1  carry in.
REQ-008 SHALL provide port Sub  input  1  mode: 0 = add, 1 = subtract.
REQ-009 SHALL provide port in_valid  input  1  A/B/Cin/Sub valid this cycle.
REQ-010 SHALL provide port in_ready  output  1  block accepts an operand set this cycle.
REQ-011 SHALL provide port Sum  output  WIDTH  result.
REQ-012 SHALL provide port Cout  output  1  carry out of bit WIDTH-1.
REQ-013 SHALL provide port Ovf  output  1  two's-complement signed overflow.
REQ-014 SHALL provide port out_valid  output  1  Sum/Cout/Ovf valid.
REQ-015 SHALL provide port out_ready  input  1  downstream accepts the result.

Function
REQ-016 SHALL compute, for Sub=0, {Cout,Sum} = A + B + Cin, modulo 2^(WIDTH+1).
REQ-017 SHALL compute, for Sub=1, {Cout,Sum} = A + ~B + Cin; Cin=1 gives A-B, Cin=0 gives A-B-1; Cout=1 means no borrow.
REQ-018 SHALL set Ovf = (opA[MSB] == opB'[MSB]) && (Sum[MSB] != opA[MSB]), where opB' is B for add and ~B for subtract.
REQ-019 SHALL split the operation into STAGES slices of WIDTH/STAGES bits; stage k adds slice k (LSB first) plus the carry registered by stage k-1.
REQ-020 SHALL carry the not-yet-added upper slices, the partial sum and the Sub-adjusted B forward in each stage register.
REQ-021 SHALL define advance = !out_valid || out_ready, and all stages SHALL shift together only when advance=1.
REQ-022 SHALL drive in_ready = advance, combinationally.
REQ-023 SHALL accept an operand set when in_valid && in_ready; when in_valid=0 and advance=1, it SHALL insert a bubble (valid bit 0).
REQ-024 SHALL have a latency of exactly STAGES cycles from acceptance to out_valid with no backpressure; throughput SHALL be 1 result per cycle.
REQ-025 SHALL, when out_valid && !out_ready, hold Sum/Cout/Ovf/out_valid stable and freeze every stage; no operand is lost or duplicated.
REQ-026 SHALL not collapse bubbles; a stalled pipeline keeps its internal gaps.
REQ-027 SHALL deliver results in acceptance order; a change of Sub between consecutive operands SHALL not affect earlier or later results.
REQ-028 SHALL, with STAGES=1, behave as a single registered adder with latency 1.

Reset
REQ-029 SHALL, on reset assertion and independent of clk, clear every stage valid bit, set out_valid=0, Sum=0, Cout=0 and Ovf=0.
REQ-030 SHALL discard all in-flight operands when reset is asserted mid-operation; none appears after release.
REQ-031 SHALL drive in_ready=1 while reset is asserted and after release (out_valid=0); the first accepted operand SHALL be the one presented on the first rising edge after release.

Verification (WIDTH=16, STAGES=4)
REQ-032 SHALL cover a basic add: A=0x1234, B=0x4321, Cin=0, Sub=0, one beat with out_ready=1 -> 4 cycles later Sum=0x5555, Cout=0, Ovf=0, out_valid high for 1 cycle.
REQ-033 SHALL cover full-width carry ripple across all slices: A=0xFFFF, B=0x0000, Cin=1 -> Sum=0x0000, Cout=1, Ovf=0.
REQ-034 SHALL cover subtraction and overflow: A=0x8000, B=0x0001, Sub=1, Cin=1 -> Sum=0x7FFF, Cout=1, Ovf=1; A=0x7FFF, B=0x0001, Sub=0, Cin=0 -> Sum=0x8000, Ovf=1.
REQ-035 SHALL cover backpressure: stream 8 random operands back-to-back, hold out_ready=0 for 5 cycles mid-stream -> in_ready=0 during the stall, outputs held, all 8 results correct and in order.
REQ-036 SHALL cover reset mid-operation: 3 operands in flight, assert reset for 1 cycle -> out_valid=0 immediately, no stale result ever emerges, and the next operand appears after 4 cycles.
REQ-037 SHALL cover a randomised check: 10k random A/B/Cin/Sub with random in_valid/out_ready against a reference model -> zero mismatches, zero lost or duplicated results.

Source files
------------

// File: rtl/pipe_adder.sv
// Pipelined add/subtract: WIDTH bits split into STAGES slices, one slice per stage,
// carry registered between stages; valid/ready handshake with whole-pipe stall.
module pipe_adder #(
  parameter int WIDTH  = 16,
  parameter int STAGES = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             Cin,
  input  logic             Sub,
  input  logic             in_valid,
  output logic             in_ready,
  output logic [WIDTH-1:0] Sum,
  output logic             Cout,
  output logic             Ovf,
  output logic             out_valid,
  input  logic             out_ready
);

  localparam int SW = WIDTH / STAGES;
  localparam int L  = STAGES - 1;
  localparam int NQ = (STAGES > 1) ? STAGES - 1 : 1;

  // operands only need to travel to the stage that consumes their last slice
  logic [NQ-1:0][WIDTH-1:0]     a_q, b_q;
  logic [STAGES-1:0][WIDTH-1:0] s_q, a_src, b_src, s_src, s_nxt;
  logic [STAGES-1:0]            c_q, v_q, c_src, v_src, c_nxt;
  logic [STAGES-1:0][SW:0]      t_sum;
  logic                         ovf_q, ovf_nxt, advance;

  assign advance   = !v_q[L] || out_ready;
  assign in_ready  = advance;
  assign Sum       = s_q[L];
  assign Cout      = c_q[L];
  assign Ovf       = ovf_q;
  assign out_valid = v_q[L];

  for (genvar k = 0; k < STAGES; k++) begin : g_src
    if (k == 0) begin : g_first
      assign a_src[k] = A;
      assign b_src[k] = Sub ? ~B : B;
      assign s_src[k] = '0;
      assign c_src[k] = Cin;
      assign v_src[k] = in_valid;
    end else begin : g_next
      assign a_src[k] = a_q[k-1];
      assign b_src[k] = b_q[k-1];
      assign s_src[k] = s_q[k-1];
      assign c_src[k] = c_q[k-1];
      assign v_src[k] = v_q[k-1];
    end
  end

  always_comb begin
    t_sum = '0;
    s_nxt = '0;
    c_nxt = '0;
    for (int k = 0; k < STAGES; k++) begin
      t_sum[k] = (SW+1)'(SW'(a_src[k] >> (k*SW)))
               + (SW+1)'(SW'(b_src[k] >> (k*SW)))
               + (SW+1)'(c_src[k]);
      s_nxt[k] = s_src[k] | (WIDTH'(t_sum[k][SW-1:0]) << (k*SW));
      c_nxt[k] = t_sum[k][SW];
    end
    ovf_nxt = (a_src[L][WIDTH-1] == b_src[L][WIDTH-1]) &&
              (s_nxt[L][WIDTH-1] != a_src[L][WIDTH-1]);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      a_q   <= '0;
      b_q   <= '0;
      s_q   <= '0;
      c_q   <= '0;
      v_q   <= '0;
      ovf_q <= 1'b0;
    end else if (advance) begin
      for (int k = 0; k < STAGES - 1; k++) begin
        a_q[k] <= a_src[k];
        b_q[k] <= b_src[k];
      end
      s_q   <= s_nxt;
      c_q   <= c_nxt;
      v_q   <= v_src;
      ovf_q <= ovf_nxt;
    end
  end

endmodule

// File: tb/tb_pipe_adder.sv
// Directed and randomised checks of pipe_adder (WIDTH=16, STAGES=4): latency,
// carry ripple, subtract/overflow, backpressure, mid-flight reset, scoreboard run.
module tb_pipe_adder;

  logic        clk = 1'b0;
  logic        reset;
  logic [15:0] A, B, Sum;
  logic        Cin, Sub, in_valid, in_ready, Cout, Ovf, out_valid, out_ready;

  int n_cmp = 0;
  int n_bad = 0;

  pipe_adder #(.WIDTH(16), .STAGES(4)) dut (
    .clk(clk), .reset(reset), .A(A), .B(B), .Cin(Cin), .Sub(Sub),
    .in_valid(in_valid), .in_ready(in_ready), .Sum(Sum), .Cout(Cout),
    .Ovf(Ovf), .out_valid(out_valid), .out_ready(out_ready)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [17:0] ref_res(input logic [15:0] a, input logic [15:0] b,
                                          input logic cin, input logic sub);
    logic [15:0] bb;
    logic [16:0] e;
    logic        o;
    bb = sub ? ~b : b;
    e  = {1'b0, a} + {1'b0, bb} + 17'(cin);
    o  = (a[15] == bb[15]) && (e[15] != a[15]);
    return {o, e};
  endfunction

  // present one operand, then expect it exactly 4 cycles later for one cycle
  task automatic run_one(input string tag, input logic [15:0] a, input logic [15:0] b,
                         input logic cin, input logic sub, input logic [17:0] exp);
    int lat;
    A = a; B = b; Cin = cin; Sub = sub; in_valid = 1'b1; out_ready = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    lat = 1;
    while (!out_valid && lat < 20) begin
      @(posedge clk); #1;
      lat++;
    end
    chk({tag, "_latency"}, lat, 4);
    chk({tag, "_result"}, {Ovf, Cout, Sum}, exp);
    @(posedge clk); #1;
    chk({tag, "_pulse"}, out_valid, 0);
  endtask

  logic [15:0] bp_a [8] = '{16'h0001, 16'hFFFF, 16'h1000, 16'h0000,
                            16'h4000, 16'h8000, 16'h00FF, 16'h1234};
  logic [15:0] bp_b [8] = '{16'h0001, 16'h0001, 16'h0001, 16'h0001,
                            16'h4000, 16'h8000, 16'h0F01, 16'h0234};
  logic        bp_c [8] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
  logic        bp_s [8] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1};
  logic [17:0] bp_x [8] = '{18'h00002, 18'h10000, 18'h10FFF, 18'h0FFFF,
                            18'h28000, 18'h30000, 18'h01000, 18'h10FFF};

  logic [17:0] sb [$];

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, observed timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int idx, got;
    reset = 1'b1; A = '0; B = '0; Cin = 1'b0; Sub = 1'b0;
    in_valid = 1'b0; out_ready = 1'b1;
    #3;
    chk("rst_out_valid", out_valid, 0);
    chk("rst_outputs", {Ovf, Cout, Sum}, 0);
    chk("rst_in_ready", in_ready, 1);
    #9 reset = 1'b0;

    run_one("basic_add", 16'h1234, 16'h4321, 1'b0, 1'b0, 18'h05555);
    run_one("ripple",    16'hFFFF, 16'h0000, 1'b1, 1'b0, 18'h10000);
    run_one("sub_ovf",   16'h8000, 16'h0001, 1'b1, 1'b1, 18'h37FFF);
    run_one("add_ovf",   16'h7FFF, 16'h0001, 1'b0, 1'b0, 18'h28000);
    run_one("sub_borrow",16'h0003, 16'h0005, 1'b0, 1'b1, 18'h0FFFD);

    // backpressure: 8 back-to-back operands, 5-cycle stall mid-stream
    idx = 0; got = 0;
    for (int cyc = 0; cyc < 60 && got < 8; cyc++) begin
      out_ready = !(cyc >= 6 && cyc < 11);
      if (idx < 8) begin
        A = bp_a[idx]; B = bp_b[idx]; Cin = bp_c[idx]; Sub = bp_s[idx]; in_valid = 1'b1;
      end else begin
        in_valid = 1'b0;
      end
      #1;
      chk("bp_in_ready", in_ready, !out_valid || out_ready);
      if (!out_ready)
        chk("bp_hold", {out_valid, Ovf, Cout, Sum}, {1'b1, bp_x[got]});
      if (out_valid && out_ready) begin
        chk("bp_result", {Ovf, Cout, Sum}, bp_x[got]);
        got++;
      end
      if (in_valid && in_ready) idx++;
      @(posedge clk); #1;
    end
    chk("bp_count", got, 8);
    in_valid = 1'b0; out_ready = 1'b1;
    @(posedge clk); #1;

    // reset with three operands in flight
    for (int i = 0; i < 3; i++) begin
      A = 16'h0100 * 16'(i + 1); B = 16'h0011; Cin = 1'b0; Sub = 1'b0; in_valid = 1'b1;
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    @(posedge clk); #1;
    chk("mid_pre_valid", {out_valid, Sum}, {1'b1, 16'h0111});
    reset = 1'b1;
    #1;
    chk("mid_rst_valid", out_valid, 0);
    chk("mid_rst_outputs", {Ovf, Cout, Sum}, 0);
    chk("mid_rst_in_ready", in_ready, 1);
    @(posedge clk); #1;
    reset = 1'b0;
    for (int i = 0; i < 8; i++) begin
      chk("mid_no_stale", out_valid, 0);
      @(posedge clk); #1;
    end
    run_one("post_rst", 16'h0ABC, 16'h0111, 1'b0, 1'b0, 18'h00BCD);

    // randomised traffic against the arithmetic reference
    for (int cyc = 0; cyc < 10000; cyc++) begin
      in_valid  = 1'($urandom_range(0, 1));
      out_ready = ($urandom_range(0, 3) != 0);
      A = 16'($urandom); B = 16'($urandom);
      Cin = 1'($urandom_range(0, 1)); Sub = 1'($urandom_range(0, 1));
      #1;
      chk("rnd_in_ready", in_ready, !out_valid || out_ready);
      if (out_valid && out_ready) begin
        if (sb.size() == 0) chk("rnd_extra", out_valid, 0);
        else chk("rnd_result", {Ovf, Cout, Sum}, sb.pop_front());
      end
      if (in_valid && in_ready) sb.push_back(ref_res(A, B, Cin, Sub));
      @(posedge clk); #1;
    end
    in_valid = 1'b0; out_ready = 1'b1;
    for (int cyc = 0; cyc < 20; cyc++) begin
      #1;
      if (out_valid) begin
        if (sb.size() == 0) chk("rnd_extra", out_valid, 0);
        else chk("rnd_result", {Ovf, Cout, Sum}, sb.pop_front());
      end
      @(posedge clk); #1;
    end
    chk("rnd_lost", sb.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
